// File: rtl/cus43_tile_pixel_gen_pkg.sv
// Shared constants, the per-layer pixel type and the ROM plane unpacker
// used by the CUS43 tile pixel generator.
package cus43_pkg;

  localparam int PIX_W      = 3;
  localparam int PIX_PER_LD = 4;
  localparam int ATTR_W     = 6;
  localparam int CNT_W      = 3;
  localparam logic [PIX_W-1:0] TRANSP = 3'd7;

  typedef struct packed {
    logic [ATTR_W-1:0] attr;
    logic [PIX_W-1:0]  pix;
    logic              opaque;
  } layer_pix_t;

  typedef logic [PIX_PER_LD-1:0][PIX_W-1:0] pix_row_t;

  // Pixel k of a load: bit2 from GDP, bits 1:0 from the two GD nibbles.
  function automatic logic [PIX_W-1:0] unpack_pix(input logic [7:0] gd,
                                                  input logic [3:0] gdp,
                                                  input logic [1:0] k);
    unpack_pix = {gdp[2'd3 - k], gd[3'd7 - {1'b0, k}], gd[{1'b0, 2'd3 - k}]};
  endfunction

endpackage

// File: rtl/cus43_tile_pixel_gen_if.sv
// Load bus from the CUS42 address generator plus the CPU register port.
// master = driver side (address generator / CPU), slave = pixel generator.
interface cus43_tile_pixel_gen_if;
  import cus43_pkg::*;

  logic              ha2;
  logic              hb2;
  logic [7:0]        gd;
  logic [3:0]        gdp;
  logic [ATTR_W-1:0] attr;
  logic              flip;
  logic              nlatch;
  logic [2:0]        ca;
  logic [7:0]        cd;

  modport master (output ha2, hb2, gd, gdp, attr, flip, nlatch, ca, cd);
  modport slave  (input  ha2, hb2, gd, gdp, attr, flip, nlatch, ca, cd);

endinterface

// File: rtl/cus43_tile_pixel_gen_layer_shifter.sv
// One scroll layer: 4-pixel shift register, 1-entry hold buffer, sticky underrun.
// Optional CUS43_FLIP_EN reverses pixel order of a load when FLIP is high at capture.
module cus43_layer_shifter
  import cus43_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [7:0]        i_gd,
  input  logic [3:0]        i_gdp,
  input  logic [ATTR_W-1:0] i_attr,
  input  logic              i_flip,
  output layer_pix_t        o_pix,
  output logic              o_underrun
);

  pix_row_t          r_sr;
  pix_row_t          r_hold;
  pix_row_t          w_row;
  logic [ATTR_W-1:0] r_sr_attr;
  logic [ATTR_W-1:0] r_hold_attr;
  logic [CNT_W-1:0]  r_count;
  logic              r_hold_vld;
  logic              r_loaded;
  logic              r_underrun;
  logic              w_last;
  logic              w_xfer;
  logic              w_starved;

`ifdef CUS43_FLIP_EN
  always_comb begin
    w_row = '0;
    for (int k = 0; k < PIX_PER_LD; k++) begin
      if (i_flip) w_row[k] = unpack_pix(i_gd, i_gdp, 2'(PIX_PER_LD - 1 - k));
      else        w_row[k] = unpack_pix(i_gd, i_gdp, 2'(k));
    end
  end
`else
  logic w_unused_flip;
  assign w_unused_flip = i_flip;

  always_comb begin
    w_row = '0;
    for (int k = 0; k < PIX_PER_LD; k++) begin
      w_row[k] = unpack_pix(i_gd, i_gdp, 2'(k));
    end
  end
`endif

  // count 1 means the last pixel leaves on this edge, so a refill lands without a bubble
  assign w_last    = (r_count <= CNT_W'(1));
  assign w_xfer    = w_last && r_hold_vld;
  assign w_starved = (r_count == '0) && !r_hold_vld && r_loaded;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr        <= '0;
      r_hold      <= '0;
      r_sr_attr   <= '0;
      r_hold_attr <= '0;
      r_count     <= '0;
      r_hold_vld  <= 1'b0;
      r_loaded    <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_sr       <= r_hold;
        r_sr_attr  <= r_hold_attr;
        r_count    <= CNT_W'(PIX_PER_LD);
        r_hold_vld <= i_load;
        if (i_load) begin
          r_hold      <= w_row;
          r_hold_attr <= i_attr;
        end
      end else if (i_load && w_last) begin
        r_sr      <= w_row;
        r_sr_attr <= i_attr;
        r_count   <= CNT_W'(PIX_PER_LD);
      end else begin
        if (r_count != '0) begin
          r_sr    <= r_sr >> PIX_W;
          r_count <= r_count - CNT_W'(1);
        end
        if (i_load) begin
          r_hold      <= w_row;
          r_hold_attr <= i_attr;
          r_hold_vld  <= 1'b1;
        end
      end
      if (i_load)    r_loaded   <= 1'b1;
      if (w_starved) r_underrun <= 1'b1;
    end
  end

  always_comb begin
    o_pix.attr   = r_sr_attr;
    o_pix.pix    = TRANSP;
    o_pix.opaque = 1'b0;
    if (r_count != '0) begin
      o_pix.pix    = r_sr[0];
      o_pix.opaque = (r_sr[0] != TRANSP);
    end
  end

  assign o_underrun = r_underrun;

endmodule

// File: rtl/cus43_tile_pixel_gen.sv
// CUS43 tile pixel generator: two layer shifters, CPU priority latch and
// registered priority/transparency mix. Optional feature macro: CUS43_FLIP_EN.
module cus43_tile_pixel_gen
  import cus43_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  cus43_tile_pixel_gen_if.slave    i_bus,
  output logic [ATTR_W+PIX_W-1:0]  o_dot,
  output logic [2:0]               o_dot_pri,
  output logic                     o_dot_opq,
  output logic [1:0]               o_underrun
);

  logic [1:0][2:0]          r_pri;
  logic                     r_started;
  layer_pix_t               w_l0;
  layer_pix_t               w_l1;
  layer_pix_t               w_top;
  layer_pix_t               w_oth;
  logic [2:0]               w_top_pri;
  logic [2:0]               w_oth_pri;
  logic [ATTR_W+PIX_W-1:0]  w_dot;
  logic [2:0]               w_pri;
  logic                     w_opq;
  logic                     w_und0;
  logic                     w_und1;
  logic [4:0]               w_unused_cd;

  assign w_unused_cd = {i_bus.cd[7:4], i_bus.cd[0]};

  cus43_layer_shifter u_layer0 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (i_bus.ha2),
    .i_gd       (i_bus.gd),
    .i_gdp      (i_bus.gdp),
    .i_attr     (i_bus.attr),
    .i_flip     (i_bus.flip),
    .o_pix      (w_l0),
    .o_underrun (w_und0)
  );

  cus43_layer_shifter u_layer1 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (i_bus.hb2),
    .i_gd       (i_bus.gd),
    .i_gdp      (i_bus.gdp),
    .i_attr     (i_bus.attr),
    .i_flip     (i_bus.flip),
    .o_pix      (w_l1),
    .o_underrun (w_und1)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pri <= '0;
    end else if (!i_bus.nlatch && i_bus.ca[1:0] == 2'b01) begin
      r_pri[i_bus.ca[2]] <= i_bus.cd[3:1];
    end
  end

  always_comb begin
    if (r_pri[0] >= r_pri[1]) begin
      w_top     = w_l0;
      w_oth     = w_l1;
      w_top_pri = r_pri[0];
      w_oth_pri = r_pri[1];
    end else begin
      w_top     = w_l1;
      w_oth     = w_l0;
      w_top_pri = r_pri[1];
      w_oth_pri = r_pri[0];
    end
    w_dot = {w_top.attr, TRANSP};
    w_pri = w_top_pri;
    w_opq = 1'b0;
    if (w_top.opaque) begin
      w_dot = {w_top.attr, w_top.pix};
      w_opq = 1'b1;
    end else if (w_oth.opaque) begin
      w_dot = {w_oth.attr, w_oth.pix};
      w_pri = w_oth_pri;
      w_opq = 1'b1;
    end
  end

  // The dot register holds its reset value until the first load after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started <= 1'b0;
      o_dot     <= '0;
      o_dot_pri <= '0;
      o_dot_opq <= 1'b0;
    end else begin
      if (i_bus.ha2 || i_bus.hb2) r_started <= 1'b1;
      if (r_started) begin
        o_dot     <= w_dot;
        o_dot_pri <= w_pri;
        o_dot_opq <= w_opq;
      end
    end
  end

  assign o_underrun = {w_und1, w_und0};

endmodule

// File: tb/tb_cus43_tile_pixel_gen.sv
// Testbench for cus43_tile_pixel_gen: directed steps plus random traffic against
// a load-queue reference model. Build with or without CUS43_FLIP_EN.
module tb_cus43_tile_pixel_gen;
  import cus43_pkg::*;

`ifdef CUS43_FLIP_EN
  localparam bit FLIP_BUILD = 1'b1;
`else
  localparam bit FLIP_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] dot;
  logic [2:0] dotPri;
  logic       dotOpq;
  logic [1:0] underrun;
  int         tests = 0;
  int         fails = 0;

  cus43_tile_pixel_gen_if bus ();

  cus43_tile_pixel_gen dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_bus      (bus),
    .o_dot      (dot),
    .o_dot_pri  (dotPri),
    .o_dot_opq  (dotOpq),
    .o_underrun (underrun)
  );

  always #5 clk = ~clk;

  // Reference model: each layer has a current load (consumed by position) and one pending load.
  int         curPix[2][4];
  int         curAttr[2];
  int         used[2];
  int         pendPix[2][4];
  int         pendAttr[2];
  bit         pendV[2];
  bit         loaded[2];
  bit         und[2];
  int         pri[2];
  bit         started;
  int         newPix[4];
  logic [8:0] expDot;
  logic [2:0] expPri;
  logic       expOpq;

  task automatic modelReset();
    for (int l = 0; l < 2; l++) begin
      used[l] = 4; pendV[l] = 0; loaded[l] = 0; und[l] = 0;
      curAttr[l] = 0; pendAttr[l] = 0; pri[l] = 0;
    end
    started = 0; expDot = '0; expPri = '0; expOpq = 1'b0;
  endtask

  task automatic buildLoad(input logic [7:0] gd, input logic [3:0] gdp, input bit flip);
    for (int k = 0; k < 4; k++) begin
      int src;
      src = (FLIP_BUILD && flip) ? 3 - k : k;
      newPix[k] = (((int'(gdp) >> (3 - src)) & 1) << 2) |
                  (((int'(gd) >> (7 - src)) & 1) << 1) |
                  ((int'(gd) >> (3 - src)) & 1);
    end
  endtask

  task automatic modelLayer(input int l, input bit s, input int na);
    bit starved;
    starved = loaded[l] && used[l] == 4 && !pendV[l];
    if (used[l] < 4) used[l]++;
    if (used[l] == 4) begin
      if (pendV[l]) begin
        for (int k = 0; k < 4; k++) curPix[l][k] = pendPix[l][k];
        curAttr[l] = pendAttr[l]; used[l] = 0; pendV[l] = s;
        if (s) begin
          for (int k = 0; k < 4; k++) pendPix[l][k] = newPix[k];
          pendAttr[l] = na;
        end
      end else if (s) begin
        for (int k = 0; k < 4; k++) curPix[l][k] = newPix[k];
        curAttr[l] = na; used[l] = 0;
      end
    end else if (s) begin
      for (int k = 0; k < 4; k++) pendPix[l][k] = newPix[k];
      pendAttr[l] = na; pendV[l] = 1;
    end
    if (s) loaded[l] = 1;
    if (starved) und[l] = 1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    check("dot", 16'(dot), 16'(expDot));
    check("dotPri", 16'(dotPri), 16'(expPri));
    check("dotOpq", 16'(dotOpq), 16'(expOpq));
    check("underrun", 16'(underrun), 16'({und[1], und[0]}));
  endtask

  // Drives one dot-clock of inputs, advances the model across the edge, then checks.
  task automatic applyStimulus(input bit ha, input bit hb, input logic [7:0] gd,
                               input logic [3:0] gdp, input logic [5:0] attr, input bit flip,
                               input bit nl, input logic [2:0] ca, input logic [7:0] cd);
    int lp[2]; int la[2]; bit lo[2]; int top; int oth;
    bus.ha2 = ha; bus.hb2 = hb; bus.gd = gd; bus.gdp = gdp; bus.attr = attr;
    bus.flip = flip; bus.nlatch = nl; bus.ca = ca; bus.cd = cd;
    for (int l = 0; l < 2; l++) begin
      la[l] = curAttr[l];
      lp[l] = (used[l] < 4) ? curPix[l][used[l]] : 7;
      lo[l] = (lp[l] != 7);
    end
    top = (pri[0] >= pri[1]) ? 0 : 1;
    oth = 1 - top;
    if (started) begin
      if (lo[top])      begin expDot = {6'(la[top]), 3'(lp[top])}; expPri = 3'(pri[top]); expOpq = 1; end
      else if (lo[oth]) begin expDot = {6'(la[oth]), 3'(lp[oth])}; expPri = 3'(pri[oth]); expOpq = 1; end
      else              begin expDot = {6'(la[top]), 3'd7};        expPri = 3'(pri[top]); expOpq = 0; end
    end
    buildLoad(gd, gdp, flip);
    modelLayer(0, ha, int'(attr));
    modelLayer(1, hb, int'(attr));
    if (!nl && ca[1:0] == 2'b01) pri[ca[2]] = (int'(cd) >> 1) & 7;
    if (ha || hb) started = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 4'h0, 6'h00, 0, 1, 3'd0, 8'h00);
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    check("rstDot", 16'(dot), 16'h0);
    check("rstPri", 16'(dotPri), 16'h0);
    check("rstOpq", 16'(dotOpq), 16'h0);
    check("rstUnd", 16'(underrun), 16'h0);
    modelReset();
    bus.ha2 = 0; bus.hb2 = 0; bus.nlatch = 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int flipExp[4];
    bus.ha2 = 0; bus.hb2 = 0; bus.gd = 0; bus.gdp = 0; bus.attr = 0;
    bus.flip = 0; bus.nlatch = 1; bus.ca = 0; bus.cd = 0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] step 1: idle after reset");
    idle(100);

    $display("[TB] step 2: layer 0 fed every 4 cycles");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i % 4 == 0, 0, 8'hF0, 4'hA, 6'h15, 0, 1, 3'd0, 8'h00);
      if (i == 1) check("firstPix", 16'(dot), 16'({6'h15, 3'd6}));
      if (i == 2) check("secondPix", 16'(dot), 16'({6'h15, 3'd2}));
    end
    check("noUnderrun", 16'(underrun), 16'h0);

    $display("[TB] step 3: layer priority");
    doReset();
    applyStimulus(0, 0, 8'h00, 4'h0, 6'h00, 0, 0, 3'b001, 8'h04);
    applyStimulus(0, 0, 8'h00, 4'h0, 6'h00, 0, 0, 3'b101, 8'h0A);
    for (int j = 0; j < 12; j++) begin
      bit s;
      s = (j % 4 == 0);
      if (s) begin
        applyStimulus(1, 0, 8'h00, 4'h0, 6'h0A, 0, 1, 3'd0, 8'h00);
        #0;
      end
      applyStimulus(0, s, 8'h11, 4'h1, 6'h2B, 0, 1, 3'd0, 8'h00);
      if (j == 1) begin
        check("pri1Dot", 16'(dot), 16'({6'h2B, 3'd0}));
        check("pri1Pri", 16'(dotPri), 16'd5);
      end
      if (j == 4) begin
        check("pri0Dot", 16'(dot), 16'({6'h0A, 3'd0}));
        check("pri0Pri", 16'(dotPri), 16'd2);
      end
    end

    $display("[TB] step 4: hold buffer fill and overwrite");
    doReset();
    applyStimulus(1, 0, 8'h00, 4'h0, 6'h01, 0, 1, 3'd0, 8'h00);
    applyStimulus(1, 0, 8'hFF, 4'hF, 6'h02, 0, 1, 3'd0, 8'h00);
    applyStimulus(1, 0, 8'hF0, 4'h0, 6'h03, 0, 1, 3'd0, 8'h00);
    idle(2);
    check("load1Last", 16'(dot), 16'({6'h01, 3'd0}));
    idle(1);
    check("load3First", 16'(dot), 16'({6'h03, 3'd2}));

    $display("[TB] step 5: starvation and reset mid-load");
    idle(6);
    check("underrunSticky", 16'(underrun[0]), 16'h1);
    applyStimulus(1, 0, 8'h5A, 4'h3, 6'h11, 0, 1, 3'd0, 8'h00);
    idle(1);
    doReset();
    idle(3);

    $display("[TB] step 6: pixel order with FLIP=1");
    if (FLIP_BUILD) begin flipExp[0] = 0; flipExp[1] = 0; flipExp[2] = 0; flipExp[3] = 7; end
    else            begin flipExp[0] = 7; flipExp[1] = 0; flipExp[2] = 0; flipExp[3] = 0; end
    applyStimulus(1, 0, 8'h88, 4'h8, 6'h2A, 1, 1, 3'd0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 8'h00, 4'h0, 6'h00, 1, 1, 3'd0, 8'h00);
      check("flipOrder", 16'(dot), 16'({6'h2A, 3'(flipExp[k])}));
    end

    $display("[TB] step 7: random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(3) == 0, $urandom_range(3) == 0, 8'($urandom),
                    4'($urandom), 6'($urandom), 1'($urandom), $urandom_range(7) != 0,
                    3'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
